// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM write-port arbiter.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CLEAR
  } arb_state_t;

  localparam int VRAM_BITS_WIDTH = 32;
  localparam int CLR_INDEX_WIDTH = 4;

  // The video controller's write word carries one byte in its low bits.
  function automatic logic [VRAM_BITS_WIDTH-1:0] pack_bits(input logic [7:0] data);
    return {{(VRAM_BITS_WIDTH-8){1'b0}}, data};
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set bit of valid scanning upward from ptr, with wrap.
module rr_picker #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = 1
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  logic [ID_WIDTH-1:0] cand;

  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
      if (valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter sharing the single VRAM byte-write port among NUM_REQ requesters.
// Define VRAM_ARB_CLEAR_EN to build the whole-VRAM clear engine.
module vram_write_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 13,
  parameter int VRAM_BYTES = 8192,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_adr,
  input  logic [NUM_REQ*8-1:0]          i_req_data,
  output logic                          o_vram_valid,
  input  logic                          i_vram_ready,
  output logic [VRAM_BITS_WIDTH-1:0]    o_vram_bits,
  output logic [ADDR_WIDTH-1:0]         o_vram_adr,
  output logic [ID_WIDTH-1:0]           o_grant_id,
  output logic                          o_busy,
  input  logic                          i_clr_start,
  input  logic [CLR_INDEX_WIDTH-1:0]    i_clr_index,
  output logic                          o_clr_busy
);

  arb_state_t          state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                pick_found;
  logic [7:0]          vram_data;

  rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .valid (i_req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] g);
    if (int'(g) >= NUM_REQ - 1) return '0;
    return g + 1'b1;
  endfunction

`ifdef VRAM_ARB_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(VRAM_BYTES - 1);
  logic [ADDR_WIDTH-1:0] clr_cnt;
`else
  logic unused_clr;
  assign unused_clr = ^{i_clr_start, i_clr_index};
`endif

  assign o_vram_bits = pack_bits(vram_data);

  // Acceptance is reported in the same cycle the controller takes the write.
  always_comb begin
    o_req_ready = '0;
    if (state == ISSUE && i_vram_ready) o_req_ready[o_grant_id] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      o_vram_valid <= 1'b0;
      o_vram_adr   <= '0;
      vram_data    <= '0;
      o_grant_id   <= '0;
      o_busy       <= 1'b0;
      o_clr_busy   <= 1'b0;
`ifdef VRAM_ARB_CLEAR_EN
      clr_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef VRAM_ARB_CLEAR_EN
          if (i_clr_start) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            o_vram_adr   <= '0;
            vram_data    <= {i_clr_index, i_clr_index};
            o_vram_valid <= 1'b1;
            o_busy       <= 1'b1;
            o_clr_busy   <= 1'b1;
          end else
`endif
          if (pick_found) begin
            state        <= ISSUE;
            o_grant_id   <= pick_idx;
            o_vram_adr   <= i_req_adr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            vram_data    <= i_req_data[pick_idx*8 +: 8];
            o_vram_valid <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        ISSUE: begin
          if (i_vram_ready) begin
            state        <= IDLE;
            rr_ptr       <= next_ptr(o_grant_id);
            o_vram_valid <= 1'b0;
            o_busy       <= 1'b0;
          end
        end
`ifdef VRAM_ARB_CLEAR_EN
        // Each clear write is followed by one idle cycle before the next address.
        CLEAR: begin
          if (o_vram_valid && i_vram_ready) begin
            o_vram_valid <= 1'b0;
            if (clr_cnt == CLR_LAST) begin
              state      <= IDLE;
              o_busy     <= 1'b0;
              o_clr_busy <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end else if (!o_vram_valid) begin
            o_vram_valid <= 1'b1;
            o_vram_adr   <= clr_cnt;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter; controller model raises ready the cycle after it sees valid.
module tb_vram_write_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_req_valid = '0;
  logic [1:0]  o_req_ready;
  logic [25:0] i_req_adr = '0;
  logic [15:0] i_req_data = '0;
  logic        o_vram_valid;
  logic        i_vram_ready = 1'b0;
  logic [31:0] o_vram_bits;
  logic [12:0] o_vram_adr;
  logic [0:0]  o_grant_id;
  logic        o_busy;
  logic        i_clr_start = 1'b0;
  logic [3:0]  i_clr_index = '0;
  logic        o_clr_busy;

  int nvec = 0;
  int nmis = 0;
  logic prev_vld = 1'b0;

  vram_write_arbiter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_adr    (i_req_adr),
    .i_req_data   (i_req_data),
    .o_vram_valid (o_vram_valid),
    .i_vram_ready (i_vram_ready),
    .o_vram_bits  (o_vram_bits),
    .o_vram_adr   (o_vram_adr),
    .o_grant_id   (o_grant_id),
    .o_busy       (o_busy),
    .i_clr_start  (i_clr_start),
    .i_clr_index  (i_clr_index),
    .o_clr_busy   (o_clr_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  vld;
    logic [12:0] adr0;
    logic [12:0] adr1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [0:0]  gnt;
    logic [12:0] eadr;
    logic [31:0] ebits;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs and the modelled ready are settled on return.
  task automatic cyc();
    @(posedge i_clk);
    #1;
    if (i_rst) begin
      i_vram_ready = 1'b0;
      prev_vld     = 1'b0;
    end else begin
      i_vram_ready = prev_vld && o_vram_valid;
      prev_vld     = o_vram_valid && !i_vram_ready;
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, o_vram_valid, 0);
    check({tag, "_bits"}, o_vram_bits, 0);
    check({tag, "_adr"}, o_vram_adr, 0);
    check({tag, "_ready"}, o_req_ready, 0);
    check({tag, "_grant"}, o_grant_id, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_clr_busy"}, o_clr_busy, 0);
  endtask

  // One complete requester transfer from IDLE, checking the 3-cycle shape.
  task automatic transfer(input string tag, input logic [1:0] vld, input logic [25:0] adr,
                          input logic [15:0] data, input logic [0:0] gnt,
                          input logic [12:0] eadr, input logic [31:0] ebits);
    i_req_valid = vld;
    i_req_adr   = adr;
    i_req_data  = data;
    cyc();
    check({tag, "_c1_valid"}, o_vram_valid, 1);
    check({tag, "_c1_adr"}, o_vram_adr, eadr);
    check({tag, "_c1_bits"}, o_vram_bits, ebits);
    check({tag, "_c1_grant"}, o_grant_id, gnt);
    check({tag, "_c1_busy"}, o_busy, 1);
    check({tag, "_c1_ready"}, o_req_ready, 0);
    cyc();
    check({tag, "_c2_ready"}, o_req_ready, 2'b01 << gnt);
    check({tag, "_c2_adr"}, o_vram_adr, eadr);
    check({tag, "_c2_bits"}, o_vram_bits, ebits);
    i_req_valid = '0;
    cyc();
    check({tag, "_c3_valid"}, o_vram_valid, 0);
    check({tag, "_c3_busy"}, o_busy, 0);
    check({tag, "_c3_ready"}, o_req_ready, 0);
  endtask

  initial begin
    tbl[0] = '{2'b01, 13'h0123, 13'h0000, 8'hA5, 8'h00, 1'b0, 13'h0123, 32'h0000_00A5};
    tbl[1] = '{2'b11, 13'h0001, 13'h1FFF, 8'h11, 8'hFF, 1'b1, 13'h1FFF, 32'h0000_00FF};
    tbl[2] = '{2'b11, 13'h0000, 13'h0ABC, 8'h00, 8'h77, 1'b0, 13'h0000, 32'h0000_0000};
    tbl[3] = '{2'b01, 13'h1000, 13'h0555, 8'h3C, 8'h99, 1'b0, 13'h1000, 32'h0000_003C};
    tbl[4] = '{2'b10, 13'h0AAA, 13'h1555, 8'h12, 8'h34, 1'b1, 13'h1555, 32'h0000_0034};
    tbl[5] = '{2'b10, 13'h0001, 13'h0002, 8'h80, 8'h7F, 1'b1, 13'h0002, 32'h0000_007F};
    tbl[6] = '{2'b11, 13'h1234, 13'h0321, 8'h5A, 8'hC3, 1'b0, 13'h1234, 32'h0000_005A};

    i_rst = 1'b1;
    cyc();
    cyc();
    check_reset_outputs("reset");
    i_rst = 1'b0;
    cyc();
    check("idle_after_reset", o_busy, 0);

    for (int v = 0; v < 7; v++)
      transfer($sformatf("vec%0d", v), tbl[v].vld, {tbl[v].adr1, tbl[v].adr0},
               {tbl[v].d1, tbl[v].d0}, tbl[v].gnt, tbl[v].eadr, tbl[v].ebits);

    // Both requesters held valid: grants 1,0,1,0 (last grant was 0), one pulse per 3 cycles.
    i_req_valid = 2'b11;
    i_req_adr   = {13'h0020, 13'h0010};
    i_req_data  = {8'h22, 8'h11};
    for (int k = 1; k <= 12; k++) begin
      automatic logic [0:0] g = (((k - 1) / 3) % 2 == 0) ? 1'b1 : 1'b0;
      cyc();
      if (k % 3 == 2) check($sformatf("cont_c%0d_ready", k), o_req_ready, 2'b01 << g);
      else check($sformatf("cont_c%0d_ready", k), o_req_ready, 0);
      if (k % 3 == 1) check($sformatf("cont_c%0d_grant", k), o_grant_id, g);
    end
    i_req_valid = '0;

    // Clear start during ISSUE is ignored.
    i_req_valid = 2'b01;
    i_req_adr   = {13'h0000, 13'h0042};
    i_req_data  = {8'h00, 8'hE1};
    cyc();
    check("clr_in_issue_grant", o_grant_id, 0);
    i_req_valid = '0;
    i_clr_start = 1'b1;
    i_clr_index = 4'h7;
    cyc();
    i_clr_start = 1'b0;
    check("clr_in_issue_clr_busy", o_clr_busy, 0);
    check("clr_in_issue_ready", o_req_ready, 2'b01);
    cyc();
    check("clr_in_issue_idle_valid", o_vram_valid, 0);
    check("clr_in_issue_idle_clr", o_clr_busy, 0);
    check("clr_in_issue_idle_busy", o_busy, 0);

    // Reset in the middle of ISSUE aborts with no acceptance pulse.
    i_req_valid = 2'b10;
    i_req_adr   = {13'h0111, 13'h0000};
    i_req_data  = {8'h66, 8'h00};
    cyc();
    check("rst_issue_valid", o_vram_valid, 1);
    check("rst_issue_grant", o_grant_id, 1);
    i_req_valid = '0;
    i_rst = 1'b1;
    cyc();
    check_reset_outputs("rst_issue");
    i_rst = 1'b0;
    transfer("post_rst_issue", 2'b10, {13'h0ABC, 13'h0000}, {8'h5A, 8'h00}, 1'b1,
             13'h0ABC, 32'h0000_005A);

`ifdef VRAM_ARB_CLEAR_EN
    begin
      int expa = 0;
      int bad  = 0;
      int n    = 0;
      // Clear with index 3 while requester 1 waits; it is granted only afterwards.
      i_req_valid = 2'b10;
      i_req_adr   = {13'h0777, 13'h0000};
      i_req_data  = {8'hC3, 8'h00};
      i_clr_start = 1'b1;
      i_clr_index = 4'h3;
      cyc();
      i_clr_start = 1'b0;
      i_clr_index = 4'hC;
      check("clr_busy_start", o_clr_busy, 1);
      check("clr_busy_overall", o_busy, 1);
      check("clr_first_valid", o_vram_valid, 1);
      check("clr_first_adr", o_vram_adr, 0);
      check("clr_first_bits", o_vram_bits, 32'h0000_0033);
      while (o_clr_busy && n < 40000) begin
        if (o_req_ready != 2'b00) bad++;
        if (o_vram_valid && i_vram_ready) begin
          if (o_vram_adr != 13'(expa) || o_vram_bits != 32'h0000_0033) begin
            if (bad < 5) $display("clear write %0d: adr %h bits %h", expa, o_vram_adr, o_vram_bits);
            bad++;
          end
          expa++;
        end
        cyc();
        n++;
      end
      check("clr_finished_in_budget", (n < 40000), 1);
      check("clr_write_count", expa, 8192);
      check("clr_bad_writes", bad, 0);
      check("clr_busy_fall", o_clr_busy, 0);
      check("clr_end_busy", o_busy, 0);
      check("clr_end_valid", o_vram_valid, 0);
      cyc();
      check("after_clr_grant", o_grant_id, 1);
      check("after_clr_valid", o_vram_valid, 1);
      check("after_clr_adr", o_vram_adr, 13'h0777);
      check("after_clr_bits", o_vram_bits, 32'h0000_00C3);
      cyc();
      check("after_clr_ready", o_req_ready, 2'b10);
      i_req_valid = '0;
      cyc();
      check("after_clr_idle", o_busy, 0);

      // Reset while clearing address 100.
      i_clr_start = 1'b1;
      i_clr_index = 4'h5;
      cyc();
      i_clr_start = 1'b0;
      n = 0;
      while (!(o_vram_valid && o_vram_adr == 13'd100) && n < 1000) begin
        cyc();
        n++;
      end
      check("clr_reached_100", (o_vram_valid && o_vram_adr == 13'd100), 1);
      check("clr_100_bits", o_vram_bits, 32'h0000_0055);
      i_rst = 1'b1;
      cyc();
      check_reset_outputs("rst_clear");
      i_rst = 1'b0;
      transfer("post_rst_clear", 2'b01, {13'h0000, 13'h1FFF}, {8'h00, 8'hFF}, 1'b0,
               13'h1FFF, 32'h0000_00FF);
    end
`else
    // Without the clear engine, a clear pulse in IDLE is ignored and requests proceed.
    i_clr_start = 1'b1;
    i_clr_index = 4'h3;
    i_req_valid = 2'b01;
    i_req_adr   = {13'h0000, 13'h1FFF};
    i_req_data  = {8'h00, 8'hFF};
    cyc();
    i_clr_start = 1'b0;
    check("noclr_clr_busy", o_clr_busy, 0);
    check("noclr_grant", o_grant_id, 0);
    check("noclr_adr", o_vram_adr, 13'h1FFF);
    check("noclr_bits", o_vram_bits, 32'h0000_00FF);
    cyc();
    check("noclr_ready", o_req_ready, 2'b01);
    i_req_valid = '0;
    cyc();
    check("noclr_idle", o_busy, 0);
    check("noclr_clr_busy_end", o_clr_busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
